// File: rtl/cluster_locate.sv
// Streaming cluster finder: tracks runs of consecutive above-threshold channels
// on the signal RAM write stream and publishes the best run at frame end.
module cluster_locate #(
    parameter int CH_NUM    = 320,
    parameter int MIN_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [15:0]            threshold,
    input  logic                          sig_valid,
    input  logic [$clog2(CH_NUM)-1:0]     sig_ch,
    input  logic signed [15:0]            sig_data,
    input  logic                          sig_last,
    output logic [$clog2(CH_NUM)-1:0]     sig_ch_left,
    output logic [$clog2(CH_NUM)-1:0]     sig_ch_right,
    output logic signed [31:0]            cluster_sum,
    output logic signed [15:0]            cluster_peak,
    output logic                          has_cluster,
    output logic                          no_cluster,
    output logic                          result_valid
);

    // state | meaning
    // IDLE  | waiting for a channel-0 beat to start a frame
    // SCAN  | frame in progress, tracking runs and the best run so far

    localparam int          CW    = $clog2(CH_NUM);
    localparam logic [8:0]  MIN_W = 9'(MIN_WIDTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state_q, state_d;
    logic                  run_open_q, run_open_d;
    logic [CW-1:0]         run_start_q, run_start_d;
    logic [CW-1:0]         run_end_q, run_end_d;
    logic signed [31:0]    run_sum_q, run_sum_d;
    logic signed [15:0]    run_peak_q, run_peak_d;
    logic [8:0]            run_len_q, run_len_d;
    logic                  best_valid_q, best_valid_d;
    logic [CW-1:0]         best_left_q, best_left_d;
    logic [CW-1:0]         best_right_q, best_right_d;
    logic signed [31:0]    best_sum_q, best_sum_d;
    logic signed [15:0]    best_peak_q, best_peak_d;
    logic [CW-1:0]         left_q, left_d;
    logic [CW-1:0]         right_q, right_d;
    logic signed [31:0]    sum_q, sum_d;
    logic signed [15:0]    peak_q, peak_d;
    logic                  has_q, has_d;
    logic                  no_q, no_d;
    logic                  rv_q, rv_d;

    logic                  beat_start, beat_act, hit, contig;
    logic signed [31:0]    data_ext;

    // Lower start channel breaks ties so out-of-order runs still resolve correctly.
    function automatic logic run_wins(input logic               bv,
                                      input logic signed [31:0] bs,
                                      input logic [CW-1:0]      bl,
                                      input logic signed [31:0] cs,
                                      input logic [CW-1:0]      cl,
                                      input logic [8:0]         len);
        return (len >= MIN_W) && (!bv || (cs > bs) || ((cs == bs) && (cl < bl)));
    endfunction

    always_comb begin
        state_d      = state_q;
        run_open_d   = run_open_q;
        run_start_d  = run_start_q;
        run_end_d    = run_end_q;
        run_sum_d    = run_sum_q;
        run_peak_d   = run_peak_q;
        run_len_d    = run_len_q;
        best_valid_d = best_valid_q;
        best_left_d  = best_left_q;
        best_right_d = best_right_q;
        best_sum_d   = best_sum_q;
        best_peak_d  = best_peak_q;
        left_d       = left_q;
        right_d      = right_q;
        sum_d        = sum_q;
        peak_d       = peak_q;
        has_d        = has_q;
        no_d         = no_q;
        rv_d         = 1'b0;
        contig       = 1'b0;

        beat_start = sig_valid && (sig_ch == '0);
        beat_act   = sig_valid && (beat_start || (state_q == SCAN));
        hit        = sig_data > threshold;
        data_ext   = {{16{sig_data[15]}}, sig_data};

        if (beat_start) begin
            run_open_d   = 1'b0;
            run_start_d  = '0;
            run_end_d    = '0;
            run_sum_d    = '0;
            run_peak_d   = '0;
            run_len_d    = '0;
            best_valid_d = 1'b0;
            best_left_d  = '0;
            best_right_d = '0;
            best_sum_d   = '0;
            best_peak_d  = '0;
        end

        if (beat_act) begin
            contig = run_open_d && (sig_ch == run_end_d + CW'(1));
            if (run_open_d && !(hit && contig)) begin
                if (run_wins(best_valid_d, best_sum_d, best_left_d,
                             run_sum_d, run_start_d, run_len_d)) begin
                    best_valid_d = 1'b1;
                    best_left_d  = run_start_d;
                    best_right_d = run_end_d;
                    best_sum_d   = run_sum_d;
                    best_peak_d  = run_peak_d;
                end
                run_open_d = 1'b0;
            end

            if (hit) begin
                if (run_open_d) begin
                    run_end_d = sig_ch;
                    run_sum_d = run_sum_d + data_ext;
                    run_len_d = run_len_d + 9'd1;
                    if (sig_data > run_peak_d)
                        run_peak_d = sig_data;
                end else begin
                    run_open_d  = 1'b1;
                    run_start_d = sig_ch;
                    run_end_d   = sig_ch;
                    run_sum_d   = data_ext;
                    run_peak_d  = sig_data;
                    run_len_d   = 9'd1;
                end
            end

            // Final close, best update and publish all land on the same edge.
            if (sig_last) begin
                if (run_open_d &&
                    run_wins(best_valid_d, best_sum_d, best_left_d,
                             run_sum_d, run_start_d, run_len_d)) begin
                    best_valid_d = 1'b1;
                    best_left_d  = run_start_d;
                    best_right_d = run_end_d;
                    best_sum_d   = run_sum_d;
                    best_peak_d  = run_peak_d;
                end
                run_open_d = 1'b0;
                rv_d       = 1'b1;
                has_d      = best_valid_d;
                no_d       = !best_valid_d;
                left_d     = best_valid_d ? best_left_d  : '0;
                right_d    = best_valid_d ? best_right_d : '0;
                sum_d      = best_valid_d ? best_sum_d   : '0;
                peak_d     = best_valid_d ? best_peak_d  : '0;
                state_d    = IDLE;
            end else if (beat_start) begin
                state_d = SCAN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            run_open_q   <= 1'b0;
            run_start_q  <= '0;
            run_end_q    <= '0;
            run_sum_q    <= '0;
            run_peak_q   <= '0;
            run_len_q    <= '0;
            best_valid_q <= 1'b0;
            best_left_q  <= '0;
            best_right_q <= '0;
            best_sum_q   <= '0;
            best_peak_q  <= '0;
            left_q       <= '0;
            right_q      <= '0;
            sum_q        <= '0;
            peak_q       <= '0;
            has_q        <= 1'b0;
            no_q         <= 1'b0;
            rv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_open_q   <= run_open_d;
            run_start_q  <= run_start_d;
            run_end_q    <= run_end_d;
            run_sum_q    <= run_sum_d;
            run_peak_q   <= run_peak_d;
            run_len_q    <= run_len_d;
            best_valid_q <= best_valid_d;
            best_left_q  <= best_left_d;
            best_right_q <= best_right_d;
            best_sum_q   <= best_sum_d;
            best_peak_q  <= best_peak_d;
            left_q       <= left_d;
            right_q      <= right_d;
            sum_q        <= sum_d;
            peak_q       <= peak_d;
            has_q        <= has_d;
            no_q         <= no_d;
            rv_q         <= rv_d;
        end
    end

    assign sig_ch_left  = left_q;
    assign sig_ch_right = right_q;
    assign cluster_sum  = sum_q;
    assign cluster_peak = peak_q;
    assign has_cluster  = has_q;
    assign no_cluster   = no_q;
    assign result_valid = rv_q;

endmodule
